// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: IDLE -> INIT -> ROUND(1..9) -> FINAL -> DONE, Moore enables from registered state.
// Optional macro AES_CTRL_BACK2BACK_EN lets DONE accept the next block directly (12-cycle throughput).
//
// state   | meaning
// IDLE    | waiting for a block, in_ready=1
// INIT    | state reg takes Message^K0, round_idx=0
// ROUND   | rounds 1..9 with mixcolumns
// FINAL   | round 10, mixcolumns bypassed
// DONE    | cipher valid, held until out_ready
module aes_round_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       load_en,
   output logic       init_sel,
   output logic       state_en,
   output logic       mix_bypass,
   output logic [3:0] round_idx,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       init_sel_q, state_en_q, mix_bypass_q, out_valid_q, busy_q;
   logic       in_ready_d;

   always_comb begin
      in_ready_d = 1'b0;
      case (state_q)
         S_IDLE:  in_ready_d = 1'b1;
`ifdef AES_CTRL_BACK2BACK_EN
         S_DONE:  in_ready_d = out_ready;
`endif
         default: in_ready_d = 1'b0;
      endcase
   end

   assign in_ready = in_ready_d;
   assign load_en  = in_ready_d & in_valid;

   always_comb begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) state_d = S_INIT;
         end
         S_INIT: begin
            state_d = S_ROUND;
            idx_d   = 4'd1;
         end
         S_ROUND: begin
            // >= rather than == so a corrupted index can never pass 10
            if (idx_q >= 4'd9) begin
               state_d = S_FINAL;
               idx_d   = 4'd10;
            end else begin
               state_d = S_ROUND;
               idx_d   = idx_q + 4'd1;
            end
         end
         S_FINAL: begin
            state_d = S_DONE;
            idx_d   = 4'd10;
         end
         S_DONE: begin
            if (!out_ready) begin
               state_d = S_DONE;
               idx_d   = 4'd10;
            end else if (load_en) begin
               state_d = S_INIT;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
         end
      endcase
   end

   // Enables are decoded from the next state so they line up with state_q without decode glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= 4'd0;
         init_sel_q   <= 1'b0;
         state_en_q   <= 1'b0;
         mix_bypass_q <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         init_sel_q   <= (state_d == S_INIT);
         state_en_q   <= (state_d == S_INIT) || (state_d == S_ROUND) || (state_d == S_FINAL);
         mix_bypass_q <= (state_d == S_FINAL);
         out_valid_q  <= (state_d == S_DONE);
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign round_idx  = idx_q;
   assign init_sel   = init_sel_q;
   assign state_en   = state_en_q;
   assign mix_bypass = mix_bypass_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;

endmodule
